// File: rtl/posit_accum_seq.sv
// posit_accum_seq
// Sequencing front-end for a multi-cycle posit adder (es=2). It folds a
// packet of posit terms, delimited by in_last, into a single running sum.
// Only one add is ever in flight: the running sum goes out on add_in1 and
// the new term on add_in2. The FSM then waits for add_done, however long
// that takes, before it accepts the next term. A NaR term, or an inf
// report from the adder, makes the packet result NaR.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   in_data/valid/last     term stream in; in_ready is the accept side
//   add_in1/add_in2        registered adder operands (sum, term)
//   add_start              registered one-cycle issue pulse
//   add_result/done/inf    adder response; ignored outside WAIT
//   out_data/inf/count     packet result, held stable while out_valid
//   out_valid/out_ready    result handshake
module posit_accum_seq #(
    parameter int NBITS = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBITS-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [NBITS-1:0] add_in1,
    output logic [NBITS-1:0] add_in2,
    output logic             add_start,
    input  logic [NBITS-1:0] add_result,
    input  logic             add_done,
    input  logic             add_inf,
    output logic [NBITS-1:0] out_data,
    output logic             out_inf,
    output logic [CNTW-1:0]  out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    localparam logic [NBITS-1:0] NAR     = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] ZERO    = {NBITS{1'b0}};
    localparam logic [CNTW-1:0]  CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]  CNT_0   = {CNTW{1'b0}};

    // NaR is the single pattern with only the sign bit set.
    function automatic logic is_nar(input logic [NBITS-1:0] v);
        return (v == NAR);
    endfunction

    // The term count sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        if (c == CNT_MAX) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    state_t           state_r, state_nx_s;
    logic [NBITS-1:0] acc_r, acc_nx_s;
    logic [CNTW-1:0]  count_r, count_nx_s;
    logic             inf_r, inf_nx_s;
    logic             last_r, last_nx_s;
    logic             issue_s;
    logic             accept_s;
    logic             in_ready_r;
    logic [NBITS-1:0] add_in1_r, add_in2_r;
    logic             add_start_r;
    logic [NBITS-1:0] out_data_r;
    logic             out_inf_r;
    logic [CNTW-1:0]  out_count_r;
    logic             out_valid_r;

    // While reset is held, nothing is offered upstream.
    assign in_ready  = in_ready_r & reset_n;
    assign accept_s  = in_valid & in_ready;
    assign add_in1   = add_in1_r;
    assign add_in2   = add_in2_r;
    assign add_start = add_start_r;
    assign out_data  = out_data_r;
    assign out_inf   = out_inf_r;
    assign out_count = out_count_r;
    assign out_valid = out_valid_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and the next value of the accumulator context.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        count_nx_s = count_r;
        inf_nx_s   = inf_r;
        last_nx_s  = last_r;
        issue_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    // The first term seeds the sum directly; no add is needed.
                    acc_nx_s   = in_data;
                    count_nx_s = CNT_ONE;
                    inf_nx_s   = is_nar(in_data);
                    last_nx_s  = in_last;
                    state_nx_s = in_last ? OUTPUT : ACCUM;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    issue_s    = 1'b1;
                    last_nx_s  = in_last;
                    count_nx_s = sat_inc(count_r);
                    inf_nx_s   = inf_r | is_nar(in_data);
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = ACCUM;
                end
            end
            WAIT: begin
                if (add_done) begin
                    acc_nx_s   = add_result;
                    inf_nx_s   = inf_r | add_inf;
                    state_nx_s = last_r ? OUTPUT : ACCUM;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    acc_nx_s   = ZERO;
                    count_nx_s = CNT_0;
                    inf_nx_s   = 1'b0;
                    last_nx_s  = 1'b0;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = OUTPUT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Accumulator context, adder issue and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_r       <= ZERO;
            count_r     <= CNT_0;
            inf_r       <= 1'b0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            add_in1_r   <= ZERO;
            add_in2_r   <= ZERO;
            add_start_r <= 1'b0;
            out_data_r  <= ZERO;
            out_inf_r   <= 1'b0;
            out_count_r <= CNT_0;
            out_valid_r <= 1'b0;
        end else begin
            acc_r       <= acc_nx_s;
            count_r     <= count_nx_s;
            inf_r       <= inf_nx_s;
            last_r      <= last_nx_s;
            in_ready_r  <= (state_nx_s == IDLE) || (state_nx_s == ACCUM);
            add_start_r <= issue_s;
            if (issue_s) begin
                add_in1_r <= acc_r;
                add_in2_r <= in_data;
            end
            out_valid_r <= (state_nx_s == OUTPUT);
            if (state_nx_s == OUTPUT) begin
                // A NaR anywhere in the packet forces the canonical NaR result.
                out_data_r  <= inf_nx_s ? NAR : acc_nx_s;
                out_inf_r   <= inf_nx_s;
                out_count_r <= count_nx_s;
            end else begin
                out_data_r  <= ZERO;
                out_inf_r   <= 1'b0;
                out_count_r <= CNT_0;
            end
        end
    end

endmodule

// File: tb/tb_posit_accum_seq.sv
// Bench for posit_accum_seq. The adder is a stand-in: it adds the two
// operands as integers and reports inf when both operands are huge. It does
// not report inf for NaR operands, so NaR detection has to come from the
// DUT. The expected packet result is a fold of the same stand-in over the
// terms. The counter is built 4 bits wide so that saturation stays reachable.
module tb_posit_accum_seq;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
    localparam int          MAXT = 24;
    localparam logic [31:0] NAR  = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   in_data = 32'h0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [31:0]   add_in1, add_in2;
    logic          add_start;
    logic [31:0]   add_result;
    logic          add_done, add_inf;
    logic [31:0]   out_data;
    logic          out_inf;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 4;

    // stand-in adder pipeline plus an injection port for stray add_done pulses
    logic [7:0]  pv = 8'h0;
    logic [7:0]  pinf = 8'h0;
    logic [31:0] pr [8];
    logic        stub_done = 1'b0, stub_inf = 1'b0;
    logic [31:0] stub_res = 32'h0;
    logic        inj_done = 1'b0, inj_inf = 1'b0;
    logic [31:0] inj_res = 32'h0;

    // monitor state
    int          start_cnt = 0;
    int          viol = 0;
    logic        outst = 1'b0;
    logic [31:0] s_in1 = 32'h0, s_in2 = 32'h0;
    int          s_cyc = 0;

    // driver results and reference model outputs
    logic [31:0]   pkt [MAXT];
    int            acc_cyc [MAXT];
    int            out_cyc;
    logic [31:0]   got_data;
    logic [CW-1:0] got_cnt;
    logic          got_inf;
    int            timeout;
    int            stable_bad;
    logic [31:0]   exp_data;
    logic          exp_inf;
    int            exp_cnt;

    posit_accum_seq #(.NBITS(32), .CNTW(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
        .add_result(add_result), .add_done(add_done), .add_inf(add_inf),
        .out_data(out_data), .out_inf(out_inf), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
        return a + b;
    endfunction

    function automatic logic stub_ovf(input logic [31:0] a, input logic [31:0] b);
        return (a[30:28] == 3'b111) && (b[30:28] == 3'b111);
    endfunction

    always @(posedge clk) begin
        pv    <= {pv[6:0], add_start};
        pinf  <= {pinf[6:0], stub_ovf(add_in1, add_in2)};
        pr[0] <= stub_sum(add_in1, add_in2);
        for (int k = 1; k < 8; k++) pr[k] <= pr[k-1];
        stub_done <= pv[lat-2];
        stub_res  <= pr[lat-2];
        stub_inf  <= pinf[lat-2];
    end

    assign add_done   = stub_done | inj_done;
    assign add_result = inj_done ? inj_res : stub_res;
    assign add_inf    = inj_done ? inj_inf : stub_inf;

    // count issue pulses; flag in_ready while an add is pending or a result is held
    always @(negedge clk) begin
        if (!reset_n) begin
            outst <= 1'b0;
        end else begin
            if (add_start) begin
                start_cnt <= start_cnt + 1;
                s_in1 <= add_in1;
                s_in2 <= add_in2;
                s_cyc <= cyc;
            end
            if (in_ready && (outst || add_start || out_valid)) viol <= viol + 1;
            if (add_start) outst <= 1'b1;
            else if (add_done) outst <= 1'b0;
        end
    end

    function automatic void model(input int n);
        logic [31:0] acc;
        logic        inf;
        acc = pkt[0];
        inf = (pkt[0] == NAR);
        for (int i = 1; i < n; i++) begin
            inf = inf | (pkt[i] == NAR) | stub_ovf(acc, pkt[i]);
            acc = stub_sum(acc, pkt[i]);
        end
        exp_data = inf ? NAR : acc;
        exp_inf  = inf;
        exp_cnt  = (n > CMAX) ? CMAX : n;
    endfunction

    function automatic logic [31:0] rand_term();
        logic [31:0] t;
        int r;
        t = $urandom();
        r = $urandom_range(0, 9);
        if (r == 0) t = NAR;
        else if (r < 3) t[30:28] = 3'b111;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer each term until it is taken, then collect the result, stall, and pop it
    task automatic drive_packet(input int n, input int stall);
        int b;
        timeout = 0;
        stable_bad = 0;
        for (int i = 0; i < n; i++) begin
            in_data = pkt[i];
            in_last = (i == n - 1);
            in_valid = 1'b1;
            b = 0;
            @(negedge clk);
            while (!in_ready && b < 200) begin
                @(negedge clk);
                b++;
            end
            if (!in_ready) timeout = 1;
            acc_cyc[i] = cyc;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = $urandom();
        b = 0;
        @(negedge clk);
        while (!out_valid && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!out_valid) timeout = 1;
        out_cyc = cyc;
        got_data = out_data;
        got_cnt = out_count;
        got_inf = out_inf;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if ({out_valid, out_data, out_count, out_inf} !== {1'b1, got_data, got_cnt, got_inf}) stable_bad++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if ({out_valid, out_inf, out_count, out_data, add_start, add_in1, add_in2} !== {2'b00, {CW{1'b0}}, 32'h0, 1'b0, 64'h0}) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b inf=%b cnt=%0d d=%h st=%b a1=%h a2=%h expected all zero",
                     out_valid, out_inf, out_count, out_data, add_start, add_in1, add_in2);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_single();
        int s0;
        s0 = start_cnt;
        pkt[0] = 32'h4000_0000;
        drive_packet(1, 0);
        n_checks++;
        if ({timeout, out_cyc} !== {0, acc_cyc[0] + 1}) begin
            n_errors++;
            $display("FAIL single_timing: got out cycle %0d (timeout %0d) expected %0d", out_cyc, timeout, acc_cyc[0] + 1);
        end
        n_checks++;
        if ({got_data, got_cnt, got_inf} !== {32'h4000_0000, 4'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL single_result: got %h/%0d/%b expected 40000000/1/0", got_data, got_cnt, got_inf);
        end
        n_checks++;
        if (start_cnt - s0 != 0) begin
            n_errors++;
            $display("FAIL single_no_add: got %0d add_start pulses expected 0", start_cnt - s0);
        end
    endtask

    task automatic test_two();
        int s0;
        s0 = start_cnt;
        pkt[0] = 32'h4000_0000;
        pkt[1] = 32'h4000_0000;
        drive_packet(2, 0);
        n_checks++;
        if ({s_in1, s_in2} !== {32'h4000_0000, 32'h4000_0000}) begin
            n_errors++;
            $display("FAIL two_operands: got %h %h expected 40000000 40000000", s_in1, s_in2);
        end
        n_checks++;
        if ((start_cnt - s0 != 1) || (s_cyc != acc_cyc[1] + 1)) begin
            n_errors++;
            $display("FAIL two_issue: got %0d pulses at cycle %0d expected 1 at %0d", start_cnt - s0, s_cyc, acc_cyc[1] + 1);
        end
        n_checks++;
        if ({timeout, out_cyc} !== {0, acc_cyc[1] + 6}) begin
            n_errors++;
            $display("FAIL two_timing: got out cycle %0d (timeout %0d) expected %0d", out_cyc, timeout, acc_cyc[1] + 6);
        end
        n_checks++;
        if ({got_data, got_cnt, got_inf} !== {32'h4800_0000, 4'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL two_result: got %h/%0d/%b expected 48000000/2/0", got_data, got_cnt, got_inf);
        end
    endtask

    task automatic test_three();
        int s0, v0;
        s0 = start_cnt;
        v0 = viol;
        pkt[0] = 32'h4000_0000;
        pkt[1] = 32'h4000_0000;
        pkt[2] = 32'hB800_0000;
        drive_packet(3, 2);
        n_checks++;
        if ({got_data, got_cnt, got_inf} !== {32'h0, 4'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL three_result: got %h/%0d/%b expected 00000000/3/0", got_data, got_cnt, got_inf);
        end
        n_checks++;
        if ((start_cnt - s0 != 2) || (viol != v0)) begin
            n_errors++;
            $display("FAIL three_issue: got %0d pulses, %0d ready violations expected 2, 0", start_cnt - s0, viol - v0);
        end
        n_checks++;
        if (acc_cyc[2] - acc_cyc[1] != 6) begin
            n_errors++;
            $display("FAIL three_throughput: got spacing %0d expected 6", acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    task automatic test_nar();
        pkt[0] = 32'h4000_0000;
        pkt[1] = NAR;
        drive_packet(2, 0);
        n_checks++;
        if ({got_data, got_cnt, got_inf} !== {NAR, 4'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL nar_result: got %h/%0d/%b expected 80000000/2/1", got_data, got_cnt, got_inf);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        in_data = 32'h4000_0000;
        in_last = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        tick();
        in_data = 32'h3C00_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid, out_data, out_count, in_ready} !== {1'b1, 32'h4000_0000, 4'd1, 1'b0}) bad++;
            inj_done = (i == 3);
            inj_res = 32'h1234_5678;
            inj_inf = 1'b1;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'h3C00_0000, 4'd1}) begin
            n_errors++;
            $display("FAIL bp_next: got v=%b %h/%0d expected v=1 3c000000/1", out_valid, out_data, out_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_stray_done();
        inj_res = 32'h1234_5678;
        inj_inf = 1'b1;
        inj_done = 1'b1;
        tick();
        tick();
        inj_done = 1'b0;
        pkt[0] = 32'h5000_0000;
        drive_packet(1, 0);
        n_checks++;
        if ({got_data, got_inf, got_cnt} !== {32'h5000_0000, 1'b0, 4'd1}) begin
            n_errors++;
            $display("FAIL stray_done: got %h/%b/%0d expected 50000000/0/1", got_data, got_inf, got_cnt);
        end
    endtask

    task automatic test_latency();
        lat = 7;
        for (int i = 0; i < 3; i++) pkt[i] = $urandom() & 32'h0FFF_FFFF;
        model(3);
        drive_packet(3, 1);
        lat = 4;
        n_checks++;
        if ({timeout, out_cyc, got_data, got_inf} !== {0, acc_cyc[2] + 9, exp_data, exp_inf}) begin
            n_errors++;
            $display("FAIL slow_adder: got cycle %0d %h/%b expected cycle %0d %h/%b",
                     out_cyc, got_data, got_inf, acc_cyc[2] + 9, exp_data, exp_inf);
        end
    endtask

    task automatic test_reset_mid_wait();
        int s0, bad;
        s0 = start_cnt;
        bad = 0;
        in_data = 32'h4000_0000;
        in_last = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midwait_reset_ready: got %b expected 0", in_ready);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, add_start} !== 3'b010) bad++;
            tick();
        end
        n_checks++;
        if ((bad != 0) || (start_cnt - s0 != 1)) begin
            n_errors++;
            $display("FAIL midwait_drop: got %0d bad cycles, %0d pulses expected 0, 1", bad, start_cnt - s0);
        end
        pkt[0] = 32'h4800_0000;
        drive_packet(1, 0);
        n_checks++;
        if ({timeout, got_data, got_cnt, got_inf} !== {0, 32'h4800_0000, 4'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL midwait_after: got %h/%0d/%b expected 48000000/1/0", got_data, got_cnt, got_inf);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) pkt[i] = rand_term();
        model(17);
        drive_packet(17, 0);
        n_checks++;
        if ({got_cnt, got_data, got_inf} !== {4'(CMAX), exp_data, exp_inf}) begin
            n_errors++;
            $display("FAIL saturate: got %0d %h/%b expected %0d %h/%b", got_cnt, got_data, got_inf, CMAX, exp_data, exp_inf);
        end
    endtask

    task automatic test_random();
        int n, st, s0, v0, exp_out;
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 20);
            st = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) pkt[i] = rand_term();
            model(n);
            s0 = start_cnt;
            v0 = viol;
            drive_packet(n, st);
            exp_out = (n == 1) ? acc_cyc[0] + 1 : acc_cyc[n-1] + 6;
            n_checks++;
            if ({got_data, got_inf} !== {exp_data, exp_inf}) begin
                n_errors++;
                $display("FAIL rand_data p%0d: got %h/%b expected %h/%b", p, got_data, got_inf, exp_data, exp_inf);
            end
            n_checks++;
            if (int'(got_cnt) != exp_cnt) begin
                n_errors++;
                $display("FAIL rand_count p%0d: got %0d expected %0d", p, got_cnt, exp_cnt);
            end
            n_checks++;
            if ({timeout, out_cyc, stable_bad} !== {0, exp_out, 0}) begin
                n_errors++;
                $display("FAIL rand_timing p%0d: got cycle %0d timeout %0d unstable %0d expected cycle %0d",
                         p, out_cyc, timeout, stable_bad, exp_out);
            end
            n_checks++;
            if ((start_cnt - s0 != n - 1) || (viol != v0)) begin
                n_errors++;
                $display("FAIL rand_issue p%0d: got %0d pulses %0d ready violations expected %0d, 0",
                         p, start_cnt - s0, viol - v0, n - 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_single();
        test_two();
        test_three();
        test_nar();
        test_backpressure();
        test_stray_done();
        test_latency();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/posit_accum_seq.md
# posit_accum_seq

Sequencing stage placed directly upstream of the 4-stage posit adder (es=2, 32-bit). It accepts a valid/ready stream of posit terms delimited by a `last` flag and feeds the adder one dependent add at a time: running sum on operand 1, new term on operand 2. It consumes the adder's `result`/`done`/`inf` and presents one accumulated posit per packet on a valid/ready output. It is the reduction front-end for dot-product and sum kernels.

## Interface
- NBITS, 32, posit width; only 32 is supported.
- CNTW, 16, width of the term counter.

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_data  in  NBITS  posit term
- in_valid  in  1  term present
- in_last  in  1  term is the final term of its packet
- in_ready  out  1  term accepted when in_valid & in_ready
- add_in1  out  NBITS  adder operand 1 (running sum), registered
- add_in2  out  NBITS  adder operand 2 (new term), registered
- add_start  out  1  one-cycle adder issue pulse, registered
- add_result  in  NBITS  adder sum
- add_done  in  1  adder result valid (single-cycle pulse)
- add_inf  in  1  adder NaR flag, qualified by add_done
- out_data  out  NBITS  accumulated posit
- out_inf  out  1  packet contained NaR or the adder reported inf
- out_count  out  CNTW  terms in packet, saturating
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts when out_valid & out_ready

## Operation
- FSM states: IDLE, ACCUM, WAIT, OUTPUT.
- IDLE: `in_ready`=1. On accept:
  - acc <= in_data, count <= 1, inf_s <= (in_data==0x80000000).
  - Next state is OUTPUT if in_last, else ACCUM.
  - No add is issued for the first term.
- ACCUM: `in_ready`=1. On accept:
  - add_in1 <= acc, add_in2 <= in_data, add_start <= 1 for exactly one cycle.
  - last_p <= in_last, count <= count+1 (saturates at 2^CNTW-1).
  - inf_s |= (in_data==0x80000000).
  - Next state WAIT.
- WAIT: `in_ready`=0. On add_done:
  - acc <= add_result, inf_s |= add_inf.
  - Next state is OUTPUT if last_p, else ACCUM.
  - The block never assumes a fixed adder latency; it waits indefinitely for add_done.
- OUTPUT: `out_valid`=1, `in_ready`=0.
  - out_data = inf_s ? 0x80000000 : acc; out_inf = inf_s; out_count = count.
  - Outputs stay stable until out_ready. On handshake → IDLE, and acc, count and inf_s clear.
- add_done outside WAIT is ignored. This covers stale results after reset.
- Only one add is in flight at any time.
- Posit arithmetic is performed solely by the adder; this block does not inspect or modify sign, regime or fraction.

## Timing
- Reset (reset_n=0 at a rising edge):
  - State → IDLE.
  - in_ready=0 during the reset cycle, 1 on the first cycle after release.
  - add_in1=add_in2=0, add_start=0.
  - out_data=0, out_inf=0, out_count=0, out_valid=0.
  - acc, count, inf_s, last_p cleared.
- Reset mid-WAIT or mid-OUTPUT: the pending add and any unsent result are dropped. A later add_done is ignored.
- Adder timing: add_start high in cycle T → add_done high in cycle T+4.
- Per-term timing in ACCUM: accept at cycle A; add_start in A+1; add_done in A+5; state ACCUM (in_ready=1) or OUTPUT from A+6. Steady-state throughput is one term per 6 cycles.
- Single-term packet: accept at A; out_valid from A+1.
- Multi-term packet: out_valid in the cycle after the final add_done.
- Handshakes:
  - in_valid may assert without waiting for in_ready.
  - in_data and in_last are sampled only on handshake.
  - out_valid never drops without out_ready.
- Simultaneous out handshake and in_valid in OUTPUT: the term is not accepted that cycle (in_ready=0). It is accepted in IDLE the next cycle.
- Count saturation: the 65536th term leaves out_count=65535. Accumulation continues.

## Test plan
- Single term: 0x40000000 with last in cycle A → out_data=0x40000000, out_count=1, out_inf=0, out_valid at A+1.
- Two terms: 1.0 (0x40000000), then 1.0 with last → add_in1=add_in2=0x40000000 with one add_start pulse. Expected out_data=0x48000000, out_count=2, out_valid 6 cycles after the second accept.
- Three terms: 0x40000000, 0x40000000, 0xB8000000 (last) → two add_start pulses; out_data=0x00000000, out_count=3, in_ready=0 throughout both WAITs.
- NaR: 0x40000000, then 0x80000000 with last → out_inf=1, out_data=0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles in OUTPUT with in_valid=1 → out_valid, out_data and out_count stable, in_ready=0. Release → handshake, then the next term is accepted in the following cycle.
- Reset mid-WAIT: pulse reset_n low 1 cycle, 2 cycles after add_start; the adder's add_done arrives afterwards → out_valid stays 0 and state stays IDLE. A following single-term packet 0x48000000 produces out_data=0x48000000.
